// File: rtl/wb_arb_if.sv
// Bus bundle for regfile_wb_arbiter: pipeline (A) and long-latency (B) write requests,
// decode hazard query and the registered register-file write port.
interface wb_arb_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a_valid;
  logic [3:0]    a_dest;
  logic [31:0]   a_data;
  logic          a_ready;
  logic          b_valid;
  logic [3:0]    b_dest;
  logic [31:0]   b_data;
  logic          b_ready;
  logic [3:0]    src1;
  logic [3:0]    src2;
  logic          hazard1;
  logic          hazard2;
  logic          writeBackEn;
  logic [3:0]    destWB;
  logic [31:0]   resultWB;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data, src1, src2,
    output a_ready, b_ready, hazard1, hazard2, writeBackEn, destWB, resultWB, fifo_count
  );

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, src1, src2,
    input  a_ready, b_ready, hazard1, hazard2, writeBackEn, destWB, resultWB, fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline (A, fixed priority) and a FIFO of
// long-latency results (B). Define WBARB_STARVE_GUARD_EN to bound B's wait to STARVE_LIMIT cycles.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic     clk,
  input logic     rst,
  wb_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][3:0]  r_dest;
  logic [DEPTH-1:0][31:0] r_data;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_wb_en;
  logic [3:0]             r_wb_dest;
  logic [31:0]            r_wb_data;

  logic                   w_nonempty;
  logic                   w_push;
  logic                   w_force_b;
  logic                   w_pop_b;
  logic                   w_issue_a;
  logic [DEPTH-1:0]       w_hit1;
  logic [DEPTH-1:0]       w_hit2;

  // b_ready looks only at the registered count, so a full FIFO refuses a push even on a pop cycle
  assign w_nonempty  = (r_count != '0);
  assign bus.b_ready = (r_count != CW'(DEPTH));
  assign w_push      = bus.b_valid & bus.b_ready;
  assign w_issue_a   = bus.a_valid & bus.a_ready;
  assign w_pop_b     = w_nonempty & (w_force_b | ~bus.a_valid);

`ifdef WBARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            r_starve <= '0;
    else if (!w_nonempty || w_pop_b)                     r_starve <= '0;
    else if (w_issue_a && r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
  end

  assign w_force_b   = (r_starve == SW'(STARVE_LIMIT));
  assign bus.a_ready = !(w_force_b & w_nonempty);
`else
  logic w_unused_limit;
  assign w_unused_limit = (STARVE_LIMIT >= 1);
  assign w_force_b      = 1'b0;
  assign bus.a_ready    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_b) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop_b);
    end
  end

  // payload storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_wr_ptr] <= bus.b_dest;
      r_data[r_wr_ptr] <= bus.b_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_en   <= 1'b0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_pop_b | w_issue_a;
      if (w_pop_b) begin
        r_wb_dest <= r_dest[r_rd_ptr];
        r_wb_data <= r_data[r_rd_ptr];
      end else if (w_issue_a) begin
        r_wb_dest <= bus.a_dest;
        r_wb_data <= bus.a_data;
      end
    end
  end

  // entry i is occupied when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] w_off;
    logic          w_occ;
    assign w_off     = AW'(i) - r_rd_ptr;
    assign w_occ     = ({1'b0, w_off} < r_count);
    assign w_hit1[i] = w_occ & (r_dest[i] == bus.src1);
    assign w_hit2[i] = w_occ & (r_dest[i] == bus.src2);
  end

  assign bus.hazard1     = (|w_hit1) | (r_wb_en & (r_wb_dest == bus.src1));
  assign bus.hazard2     = (|w_hit2) | (r_wb_en & (r_wb_dest == bus.src2));
  assign bus.writeBackEn = r_wb_en;
  assign bus.destWB      = r_wb_dest;
  assign bus.resultWB    = r_wb_data;
  assign bus.fifo_count  = r_count;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised bench for regfile_wb_arbiter against a queue-based reference model;
// follows WBARB_STARVE_GUARD_EN the same way the design does.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef WBARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_arb_if #(.DEPTH(DEPTH)) bus();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  ent_t        q[$];
  int          starve = 0;
  logic        m_en = 1'b0;
  logic [3:0]  m_dest = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_force();
    return GUARD && (starve == LIMIT) && (q.size() > 0);
  endfunction

  function automatic bit m_hazard(input logic [3:0] src);
    bit h = m_en && (m_dest == src);
    foreach (q[i]) if (q[i].d == src) h = 1'b1;
    return h;
  endfunction

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_en   = 1'b0;
    m_dest = '0;
    m_data = '0;
  endtask

  task automatic check_all();
    chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
    chk("a_ready", 32'(bus.a_ready), 32'(!m_force()));
    chk("b_ready", 32'(bus.b_ready), 32'(q.size() != DEPTH));
    chk("hazard1", 32'(bus.hazard1), 32'(m_hazard(bus.src1)));
    chk("hazard2", 32'(bus.hazard2), 32'(m_hazard(bus.src2)));
    chk("writeBackEn", 32'(bus.writeBackEn), 32'(m_en));
    if (m_en) begin
      chk("destWB", 32'(bus.destWB), 32'(m_dest));
      chk("resultWB", bus.resultWB, m_data);
    end
  endtask

  // arbitration rules applied to the model for the edge about to happen
  task automatic model_step();
    int sz = q.size();
    bit f  = m_force();
    bit pop   = (sz > 0) && (f || !bus.a_valid);
    bit issue = bus.a_valid && !f;
    bit push  = bus.b_valid && (sz != DEPTH);
    if (pop) begin
      m_en = 1'b1; m_dest = q[0].d; m_data = q[0].v;
    end else if (issue) begin
      m_en = 1'b1; m_dest = bus.a_dest; m_data = bus.a_data;
    end else begin
      m_en = 1'b0;
    end
    if (sz == 0 || pop) starve = 0;
    else if (issue && starve < LIMIT) starve++;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{bus.b_dest, bus.b_data});
  endtask

  task automatic cyc(input bit av, input logic [3:0] ad, input logic [31:0] ax,
                     input bit bv, input logic [3:0] bd, input logic [31:0] bx,
                     input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    bus.a_valid = av; bus.a_dest = ad; bus.a_data = ax;
    bus.b_valid = bv; bus.b_dest = bd; bus.b_data = bx;
    bus.src1 = s1; bus.src2 = s2;
    #1;
    check_all();
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 4'hF, 4'hE);
  endtask

  initial begin
    int lows;
    bus.a_valid = 0; bus.a_dest = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_dest = 0; bus.b_data = 0;
    bus.src1 = 0; bus.src2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_fifo_count", 32'(bus.fifo_count), 0);
    chk("rst_wb_en", 32'(bus.writeBackEn), 0);
    chk("rst_destWB", 32'(bus.destWB), 0);
    chk("rst_resultWB", bus.resultWB, 0);
    chk("rst_b_ready", 32'(bus.b_ready), 1);
    chk("rst_a_ready", 32'(bus.a_ready), 1);
    rst = 1'b1;

    // A only
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("a_only_en", 32'(bus.writeBackEn), 1);
    chk("a_only_dest", 32'(bus.destWB), 5);
    chk("a_only_data", bus.resultWB, 32'hDEADBEEF);
    idle(1);

    // B latency: not eligible the cycle after push, written the cycle after that
    cyc(0, 0, 0, 1, 7, 32'h1234, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_lat_not_yet", 32'(bus.writeBackEn), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_lat_dest", 32'(bus.destWB), 7);
    chk("b_lat_data", bus.resultWB, 32'h1234);
    idle(2);

    // FIFO full under continuous A
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'hA0 + i, 1, 4'(8 + i), 32'hB0 + i, 0, 0);
    cyc(1, 1, 32'hA4, 1, 12, 32'hB4, 0, 0);
    chk("full_b_ready", 32'(bus.b_ready), 0);
    chk("full_count", 32'(bus.fifo_count), 4);
    idle(7);

    // starve guard: one B entry behind continuous A
    lows = 0;
    cyc(1, 2, 32'hC0, 1, 6, 32'h66, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2, 32'hC1 + i, 0, 0, 0, 0, 0);
      if (!bus.a_ready) lows++;
    end
    chk("starve_a_ready_lows", 32'(lows), GUARD ? 1 : 0);
    idle(3);

    // hazard
    cyc(1, 1, 32'h11, 1, 3, 32'h33, 3, 4);
    cyc(1, 1, 32'h12, 0, 0, 0, 3, 4);
    chk("hazard1_set", 32'(bus.hazard1), 1);
    chk("hazard2_clr", 32'(bus.hazard2), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 3, 4);
    chk("hazard1_gone", 32'(bus.hazard1), 0);

    // reset flush mid-cycle
    cyc(1, 1, 32'h21, 1, 9, 32'hBAD00001, 0, 0);
    cyc(1, 1, 32'h22, 1, 10, 32'hBAD00002, 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("flush_count", 32'(bus.fifo_count), 0);
    chk("flush_wb_en", 32'(bus.writeBackEn), 0);
    model_reset();
    @(negedge clk);
    bus.a_valid = 0; bus.b_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, 4'($urandom), $urandom,
          $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
          4'($urandom), 4'($urandom));
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
